hilo_acc_reg: RTL and testbench
===============================

Name: hilo_acc_reg

Overview:
- Parametrised HI/LO special-register unit for the MIPS datapath; successor to the plain HI/LO register.
- Adds width parametrisation, encoded write modes, and a two-cycle split-carry multiply-accumulate (MADD/MSUB) path with valid/ready handshake.
- Sits after the EX-stage multiplier/divider; hi_o/lo_o feed MFHI/MFLO.

Parameters:
WIDTH, 32, width of each of HI and LO; accumulator width is 2*WIDTH.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
valid_i  input  1  operation request
ready_o  output  1  unit can accept a request this cycle
op_i  input  3  000 NOP, 001 WHI, 010 WLO, 011 WBOTH, 100 MADD, 101 MSUB, 110 CLR, 111 reserved (treated as NOP)
hi_i  input  WIDTH  HI operand (write data or upper half of addend)
lo_i  input  WIDTH  LO operand (write data or lower half of addend)
hi_o  output  WIDTH  current HI value, registered
lo_o  output  WIDTH  current LO value, registered
busy_o  output  1  accumulate in flight (equals ~ready_o)
done_o  output  1  one-cycle pulse on the cycle after an accumulate commits
ovf_o  output  1  sticky signed-overflow flag (see Optional Feature)

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset values: hi_o=0, lo_o=0, ready_o=1, busy_o=0, done_o=0, ovf_o=0, state=IDLE.
- Accept: request accepted when valid_i & ready_o at a rising edge; valid_i while ready_o=0 is ignored (not queued).
- FSM states: IDLE, ACC_LO, ACC_HI.
- IDLE:
  - WHI: hi_o<=hi_i next edge; LO unchanged.
  - WLO: lo_o<=lo_i; HI unchanged.
  - WBOTH: both updated same edge.
  - CLR: both cleared (and ovf_o cleared).
  - Direct ops are single-cycle, stay in IDLE, never deassert ready_o, and may be issued back-to-back.
  - MADD/MSUB: latch {hi_i,lo_i} as operand B and the op into internal registers; go to ACC_LO.
- ACC_LO (ready_o=0):
  - Compute lo_o + B[WIDTH-1:0] (MADD) or lo_o + ~B[WIDTH-1:0] + 1 (MSUB).
  - Register the WIDTH-bit low sum and carry-out; go to ACC_HI.
- ACC_HI (ready_o=0):
  - Compute hi_o + B_hi + carry (MADD) or hi_o + ~B_hi + carry (MSUB).
  - At the end of this cycle, hi_o and lo_o are written simultaneously; go to IDLE; done_o=1 for the following cycle.
- Architectural HI/LO never show a half-updated value. hi_o/lo_o hold the old value throughout ACC_LO/ACC_HI.
- Latency: accept edge -> result visible 2 edges later. ready_o returns to 1 in the same cycle done_o=1, so a new request can be accepted in that cycle.
- Arithmetic: two's-complement modulo 2^(2*WIDTH). Wrap-around is silent apart from ovf_o.
- Reset during ACC_LO/ACC_HI: aborts the operation. Outputs take reset values; no commit; no done_o pulse.
- Reserved op 111 with valid_i: no state change.

Optional Feature:
- Macro: HILO_OVF_FLAG_EN.
- Defined:
  - ovf_o is set at commit if a MADD/MSUB signed result overflows 2*WIDTH bits: operand signs equal (B negated for MSUB) and result sign differs.
  - Sticky until CLR or rst.
  - Direct writes (WHI/WLO/WBOTH) do not change it.
- Undefined: ovf_o tied to 0 and no overflow logic is synthesised; all other behaviour is identical.

Test Plan:
- Reset then WBOTH hi_i=0x12345678, lo_i=0x9ABCDEF0 -> next edge hi_o=0x12345678, lo_o=0x9ABCDEF0; ready_o stays 1.
- WHI 0xAAAA0000 followed by WLO 0x0000BBBB on consecutive cycles -> hi_o=0xAAAA0000, lo_o=0x0000BBBB; no stall.
- HI=0, LO=0xFFFFFFFF, MADD B=0x00000000_00000001:
  - ready_o=0 for 2 cycles; hi_o/lo_o unchanged meanwhile.
  - Then hi_o=0x00000001, lo_o=0x00000000 (carry propagates); done_o pulses once.
- HI=0, LO=0, MSUB B=1 -> hi_o=lo_o=0xFFFFFFFF; ovf_o=0. Request with valid_i asserted during ACC_LO is dropped.
- With HILO_OVF_FLAG_EN: HI=0x7FFFFFFF, LO=0xFFFFFFFF, MADD B=1 -> hi_o=0x80000000, lo_o=0, ovf_o=1; stays 1 after WBOTH; cleared by CLR.
- Assert rst during ACC_HI of a MADD -> next cycle hi_o=lo_o=0, ready_o=1, done_o never pulses.

Source files
------------

// File: rtl/hilo_acc_reg.sv
// HI/LO special-register unit with split-carry MADD/MSUB.
// Optional sticky overflow flag: define HILO_OVF_FLAG_EN.
module hilo_acc_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             ovf_o
);

   localparam logic [2:0] OP_WHI   = 3'b001;
   localparam logic [2:0] OP_WLO   = 3'b010;
   localparam logic [2:0] OP_WBOTH = 3'b011;
   localparam logic [2:0] OP_MADD  = 3'b100;
   localparam logic [2:0] OP_MSUB  = 3'b101;
   localparam logic [2:0] OP_CLR   = 3'b110;

   typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic [2*WIDTH-1:0] b_q;
   logic               sub_q;
   logic [WIDTH-1:0]   lo_sum_q;
   logic               carry_q;
   logic               done_q;
   logic               accept;
   logic               is_acc;
   logic [WIDTH-1:0]   b_lo_eff, b_hi_eff;
   logic [WIDTH:0]     lo_sum;
   logic [WIDTH-1:0]   hi_sum;

   assign accept  = valid_i && (state_q == IDLE);
   assign is_acc  = (op_i == OP_MADD) || (op_i == OP_MSUB);
   assign ready_o = (state_q == IDLE);
   assign busy_o  = ~ready_o;
   assign done_o  = done_q;
   assign hi_o    = hi_q;
   assign lo_o    = lo_q;

   // MSUB adds ~B + 1: the +1 enters as carry-in of the low half
   assign b_lo_eff = sub_q ? ~b_q[WIDTH-1:0] : b_q[WIDTH-1:0];
   assign b_hi_eff = sub_q ? ~b_q[2*WIDTH-1:WIDTH] : b_q[2*WIDTH-1:WIDTH];
   assign lo_sum   = {1'b0, lo_q} + {1'b0, b_lo_eff}
                   + (WIDTH+1)'(sub_q);
   assign hi_sum   = hi_q + b_hi_eff + WIDTH'(carry_q);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept && is_acc) state_d = ACC_LO;
         ACC_LO:  state_d = ACC_HI;
         ACC_HI:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q     <= '0;
         lo_q     <= '0;
         b_q      <= '0;
         sub_q    <= 1'b0;
         lo_sum_q <= '0;
         carry_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  unique case (op_i)
                     OP_WHI:   hi_q <= hi_i;
                     OP_WLO:   lo_q <= lo_i;
                     OP_WBOTH: begin
                        hi_q <= hi_i;
                        lo_q <= lo_i;
                     end
                     OP_CLR: begin
                        hi_q <= '0;
                        lo_q <= '0;
                     end
                     OP_MADD, OP_MSUB: begin
                        b_q   <= {hi_i, lo_i};
                        sub_q <= (op_i == OP_MSUB);
                     end
                     default: ;
                  endcase
               end
            end
            ACC_LO: begin
               lo_sum_q <= lo_sum[WIDTH-1:0];
               carry_q  <= lo_sum[WIDTH];
            end
            ACC_HI: begin
               hi_q   <= hi_sum;
               lo_q   <= lo_sum_q;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef HILO_OVF_FLAG_EN
   logic ovf_q;
   logic ovf_set;

   // hi_q/b_hi_eff carry the operand signs; hi_sum carries the result sign
   assign ovf_set = (hi_q[WIDTH-1] == b_hi_eff[WIDTH-1])
                 && (hi_sum[WIDTH-1] != hi_q[WIDTH-1]);

   always_ff @(posedge clk) begin
      if (rst)
         ovf_q <= 1'b0;
      else if (accept && (op_i == OP_CLR))
         ovf_q <= 1'b0;
      else if ((state_q == ACC_HI) && ovf_set)
         ovf_q <= 1'b1;
   end

   assign ovf_o = ovf_q;
`else
   assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_acc_reg.sv
// Scoreboard bench for hilo_acc_reg against a 64-bit reference model.
module tb_hilo_acc_reg;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         valid_i;
   logic         ready_o;
   logic [2:0]   op_i;
   logic [W-1:0] hi_i, lo_i;
   logic [W-1:0] hi_o, lo_o;
   logic         busy_o, done_o, ovf_o;

   hilo_acc_reg #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
      .op_i(op_i), .hi_i(hi_i), .lo_i(lo_i), .hi_o(hi_o), .lo_o(lo_o),
      .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         rdy;
      logic         done;
      logic         ovf;
   } exp_t;

   exp_t          exp_q[$];
   logic [2*W-1:0] res_q[$];

   int n_cmp = 0;
   int n_err = 0;

   // reference model: architectural {HI,LO}, pending result, cycles left
   logic [2*W-1:0] m_acc = '0;
   logic [2*W-1:0] m_pend = '0;
   logic           m_pend_ovf = 1'b0;
   int             m_left = 0;
   logic           m_ovf = 1'b0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("hi_o", 64'(hi_o), 64'(e.hi));
         chk("lo_o", 64'(lo_o), 64'(e.lo));
         chk("ready_o", 64'(ready_o), 64'(e.rdy));
         chk("busy_o", 64'(busy_o), 64'(!e.rdy));
         chk("done_o", 64'(done_o), 64'(e.done));
         chk("ovf_o", 64'(ovf_o), 64'(e.ovf));
      end
      if (done_o === 1'b1) begin
         if (res_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: got 1 expected 0");
         end else begin
            chk("acc_result", {hi_o, lo_o}, res_q.pop_front());
         end
      end
   end

   task automatic model_edge(input logic r, input logic v,
                             input logic [2:0] op,
                             input logic [W-1:0] hi, input logic [W-1:0] lo);
      logic done;
      logic signed [2*W:0] ex;
      logic [2*W-1:0] b;
      exp_t e;
      done = 1'b0;
      b = {hi, lo};
      if (r) begin
         m_acc = '0;
         m_left = 0;
         m_ovf = 1'b0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_acc = m_pend;
            m_ovf = m_ovf | m_pend_ovf;
            done = 1'b1;
            res_q.push_back(m_pend);
         end
      end else if (v) begin
         case (op)
            3'b001: m_acc[2*W-1:W] = hi;
            3'b010: m_acc[W-1:0] = lo;
            3'b011: m_acc = b;
            3'b110: begin
               m_acc = '0;
               m_ovf = 1'b0;
            end
            3'b100, 3'b101: begin
               if (op == 3'b100)
                  ex = $signed({m_acc[2*W-1], m_acc}) + $signed({b[2*W-1], b});
               else
                  ex = $signed({m_acc[2*W-1], m_acc}) - $signed({b[2*W-1], b});
               m_pend = ex[2*W-1:0];
               m_pend_ovf = ex[2*W] ^ ex[2*W-1];
               m_left = 2;
            end
            default: ;
         endcase
      end
      e.hi = m_acc[2*W-1:W];
      e.lo = m_acc[W-1:0];
      e.rdy = (m_left == 0);
      e.done = done;
`ifdef HILO_OVF_FLAG_EN
      e.ovf = m_ovf;
`else
      e.ovf = 1'b0;
`endif
      exp_q.push_back(e);
   endtask

   task automatic step(input logic r, input logic v, input logic [2:0] op,
                       input logic [W-1:0] hi, input logic [W-1:0] lo);
      rst = r;
      valid_i = v;
      op_i = op;
      hi_i = hi;
      lo_i = lo;
      @(posedge clk);
      model_edge(r, v, op, hi, lo);
      #1;
   endtask

   function automatic logic [W-1:0] rnd_word();
      case ($urandom_range(0, 5))
         0: rnd_word = '0;
         1: rnd_word = '1;
         2: rnd_word = 32'h7FFF_FFFF;
         3: rnd_word = 32'h8000_0000;
         default: rnd_word = $urandom;
      endcase
   endfunction

   initial begin
      rst = 1'b1;
      valid_i = 1'b0;
      op_i = 3'b000;
      hi_i = '0;
      lo_i = '0;
      #1;
      step(1, 0, 3'b000, 0, 0);
      step(1, 0, 3'b000, 0, 0);
      step(0, 1, 3'b011, 32'h1234_5678, 32'h9ABC_DEF0);
      step(0, 1, 3'b001, 32'hAAAA_0000, 32'h0);
      step(0, 1, 3'b010, 32'h0, 32'h0000_BBBB);
      // carry across halves
      step(0, 1, 3'b011, 32'h0, 32'hFFFF_FFFF);
      step(0, 1, 3'b100, 32'h0, 32'h1);
      step(0, 0, 3'b000, 0, 0);
      step(0, 0, 3'b000, 0, 0);
      // MSUB with request dropped while busy
      step(0, 1, 3'b110, 0, 0);
      step(0, 1, 3'b101, 32'h0, 32'h1);
      step(0, 1, 3'b011, 32'h5555_5555, 32'h5555_5555);
      step(0, 0, 3'b000, 0, 0);
      step(0, 1, 3'b111, 32'h1, 32'h1);
      // signed overflow, sticky across WBOTH, cleared by CLR
      step(0, 1, 3'b011, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
      step(0, 1, 3'b100, 32'h0, 32'h1);
      step(0, 0, 3'b000, 0, 0);
      step(0, 0, 3'b000, 0, 0);
      step(0, 1, 3'b011, 32'h1, 32'h2);
      step(0, 1, 3'b110, 0, 0);
      // reset during ACC_HI aborts
      step(0, 1, 3'b011, 32'h3, 32'h4);
      step(0, 1, 3'b100, 32'h1, 32'h1);
      step(0, 0, 3'b000, 0, 0);
      step(1, 0, 3'b000, 0, 0);
      step(0, 0, 3'b000, 0, 0);
      step(0, 0, 3'b000, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         logic [2:0] op;
         op = ($urandom_range(0, 2) == 0) ? 3'(4 + $urandom_range(0, 1))
                                          : 3'($urandom_range(0, 7));
         step(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0),
              op, rnd_word(), rnd_word());
      end
      for (int i = 0; i < 4; i++) step(0, 0, 3'b000, 0, 0);
      @(negedge clk);
      #1;
      chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
      chk("res_queue_drained", 64'(res_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
